// File: rtl/sync_fifo_ctl_if.sv
// Bus interface for sync_fifo_ctl: request/data inputs, data/status/error outputs.
// The master drives requests; the slave (the FIFO) drives data and status.
interface sync_fifo_ctl_if #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
);

  logic             flush;
  logic             push;
  logic             pop;
  logic             err_clr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             a_full;
  logic             a_empty;
  logic             overflow;
  logic             underflow;

  modport master (
    output flush, push, pop, err_clr, din,
    input  dout, count, full, empty, a_full, a_empty, overflow, underflow
  );

  modport slave (
    input  flush, push, pop, err_clr, din,
    output dout, count, full, empty, a_full, a_empty, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_ctl.sv
// sync_fifo_ctl: single-clock FIFO controller with any DEPTH >= 2 (non-power-of-2
// pointers wrap at DEPTH-1), exact fill count, almost-full/empty flags, synchronous
// flush and overflow/underflow reporting. Show-ahead read: dout is the current head.
// Optional build macro SYNC_FIFO_STICKY_ERR_EN makes overflow/underflow sticky until
// err_clr; without it they are one-cycle pulses and err_clr is ignored.
module sync_fifo_ctl #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned AF_LEVEL = 1,
  parameter int unsigned AE_LEVEL = 1,
  parameter int unsigned PTR_W    = $clog2(DEPTH),
  parameter int unsigned CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst,
  sync_fifo_ctl_if.slave bus
);

  // Reject illegal configurations at elaboration
  generate
    if (DEPTH < 2) begin : g_bad_depth
      $error("sync_fifo_ctl: DEPTH must be >= 2");
    end
    if (AF_LEVEL >= DEPTH) begin : g_bad_af
      $error("sync_fifo_ctl: AF_LEVEL must be < DEPTH");
    end
    if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("sync_fifo_ctl: AE_LEVEL must be < DEPTH");
    end
  endgenerate

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             overflow_q;
  logic             underflow_q;

  logic             full_c;
  logic             empty_c;
  logic             wr_en_c;
  logic             rd_en_c;
  logic             ovf_evt_c;
  logic             udf_evt_c;

  // Pointer advance with explicit wrap so non-power-of-2 depths work
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Status and acceptance; a push into a full FIFO is allowed when a pop frees a slot
  always_comb begin
    full_c    = (count_q == CNT_W'(DEPTH));
    empty_c   = (count_q == '0);
    wr_en_c   = bus.push & (~full_c | bus.pop);
    rd_en_c   = bus.pop & ~empty_c;
    ovf_evt_c = bus.push & ~wr_en_c;
    udf_evt_c = bus.pop & ~rd_en_c;
  end

  // Pointers and fill count; flush clears them like reset but leaves error flags alone
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (bus.flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_c) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (rd_en_c) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (wr_en_c && !rd_en_c) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en_c && rd_en_c) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Storage array; never cleared, stale contents are hidden by the count
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst && !bus.flush) begin
      mem[wr_ptr] <= bus.din;
    end
  end

`ifdef SYNC_FIFO_STICKY_ERR_EN
  // Sticky error flags; a new error in the same cycle as err_clr keeps the flag set
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt_c | (overflow_q  & ~bus.err_clr);
      underflow_q <= udf_evt_c | (underflow_q & ~bus.err_clr);
    end
  end
`else
  // One-cycle error pulses reporting the previous cycle's rejected requests
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= ovf_evt_c;
      underflow_q <= udf_evt_c;
    end
  end

  logic err_clr_unused;
  assign err_clr_unused = bus.err_clr;
`endif

  // Output mapping; dout is forced to zero when nothing is stored
  assign bus.dout      = empty_c ? '0 : mem[rd_ptr];
  assign bus.count     = count_q;
  assign bus.full      = full_c;
  assign bus.empty     = empty_c;
  assign bus.a_full    = (count_q >= CNT_W'(DEPTH - AF_LEVEL));
  assign bus.a_empty   = (count_q <= CNT_W'(AE_LEVEL));
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

endmodule

// File: tb/tb_sync_fifo_ctl.sv
// Self-checking bench for sync_fifo_ctl: DEPTH=5 instance for wrap/boundary/flush/error
// scenarios and a DEPTH=8, AF_LEVEL=2 instance for the almost flags.
module tb_sync_fifo_ctl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  sync_fifo_ctl_if #(.DEPTH(5), .WIDTH(8)) b5 ();
  sync_fifo_ctl_if #(.DEPTH(8), .WIDTH(8)) b8 ();

  sync_fifo_ctl #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(1), .AE_LEVEL(1)) u_dut5 (
    .clk (clk),
    .rst (rst),
    .bus (b5.slave)
  );

  sync_fifo_ctl #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(2), .AE_LEVEL(1)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (b8.slave)
  );

  // Reference model for the DEPTH=5 instance
  logic [7:0]  sb5[$];
  int unsigned m_cnt5;
  logic        exp_ovf5;
  logic        exp_udf5;
  logic        did_rd5;
  logic [7:0]  rd_exp5;
  logic [7:0]  rd_got5;

  function automatic logic [7:0] head5();
    return (sb5.size() == 0) ? 8'h00 : sb5[0];
  endfunction

  // One clock of stimulus on the DEPTH=5 instance; updates the model and scoreboard
  task automatic drive5(input logic pu, input logic po, input logic [7:0] d,
                        input logic fl, input logic ec);
    logic wr;
    logic rd;
    wr = pu && (m_cnt5 < 5 || po);
    rd = po && (m_cnt5 != 0);
    b5.push = pu; b5.pop = po; b5.din = d; b5.flush = fl; b5.err_clr = ec;
    did_rd5 = 1'b0;
    if (fl) begin
      sb5.delete();
      m_cnt5 = 0;
    end else begin
      if (rd) begin
        rd_exp5 = sb5.pop_front();
        rd_got5 = b5.dout;
        did_rd5 = 1'b1;
      end
      if (wr) sb5.push_back(d);
      m_cnt5 = m_cnt5 + (wr ? 1 : 0) - (rd ? 1 : 0);
    end
`ifdef SYNC_FIFO_STICKY_ERR_EN
    exp_ovf5 = (pu && !wr) || (exp_ovf5 && !ec);
    exp_udf5 = (po && !rd) || (exp_udf5 && !ec);
`else
    exp_ovf5 = pu && !wr;
    exp_udf5 = po && !rd;
`endif
    @(posedge clk);
    #1;
    b5.push = 1'b0; b5.pop = 1'b0; b5.flush = 1'b0; b5.err_clr = 1'b0;
  endtask

  task automatic reset_cycles(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    sb5.delete();
    m_cnt5   = 0;
    exp_ovf5 = 1'b0;
    exp_udf5 = 1'b0;
  endtask

  task automatic test_reset();
    reset_cycles(2);
    total++; if (b5.count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", b5.count); end
    total++; if (b5.empty !== 1'b1) begin bad++; $display("FAIL rst_empty: got %b want 1", b5.empty); end
    total++; if (b5.full !== 1'b0) begin bad++; $display("FAIL rst_full: got %b want 0", b5.full); end
    total++; if (b5.a_empty !== 1'b1) begin bad++; $display("FAIL rst_a_empty: got %b want 1", b5.a_empty); end
    total++; if (b5.a_full !== 1'b0) begin bad++; $display("FAIL rst_a_full: got %b want 0", b5.a_full); end
    total++; if (b5.dout !== 8'h00) begin bad++; $display("FAIL rst_dout: got %h want 00", b5.dout); end
    total++; if (b5.overflow !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %b want 0", b5.overflow); end
    total++; if (b5.underflow !== 1'b0) begin bad++; $display("FAIL rst_udf: got %b want 0", b5.underflow); end
    total++; if (b8.count !== 4'd0) begin bad++; $display("FAIL rst8_count: got %0d want 0", b8.count); end
    total++; if (b8.a_full !== 1'b0) begin bad++; $display("FAIL rst8_a_full: got %b want 0", b8.a_full); end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 5; i++) begin
        drive5(1'b1, 1'b0, 8'(8'h11 + i), 1'b0, 1'b0);
        total++; if (b5.count !== 3'(m_cnt5)) begin bad++; $display("FAIL wrap_fill_count: got %0d want %0d", b5.count, m_cnt5); end
        total++; if (b5.dout !== 8'h11) begin bad++; $display("FAIL wrap_fill_head: got %h want 11", b5.dout); end
      end
      total++; if (b5.full !== 1'b1) begin bad++; $display("FAIL wrap_full: got %b want 1", b5.full); end
      total++; if (b5.count !== 3'd5) begin bad++; $display("FAIL wrap_count5: got %0d want 5", b5.count); end
      for (int i = 0; i < 5; i++) begin
        drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        total++; if (did_rd5 !== 1'b1 || rd_got5 !== 8'(8'h11 + i)) begin bad++; $display("FAIL wrap_pop_data: got %h want %h", rd_got5, 8'(8'h11 + i)); end
        total++; if (b5.dout !== head5()) begin bad++; $display("FAIL wrap_next_head: got %h want %h", b5.dout, head5()); end
      end
      total++; if (b5.empty !== 1'b1) begin bad++; $display("FAIL wrap_empty: got %b want 1", b5.empty); end
      total++; if (b5.dout !== 8'h00) begin bad++; $display("FAIL wrap_empty_dout: got %h want 00", b5.dout); end
    end
  endtask

  task automatic test_full_boundary();
    for (int i = 0; i < 5; i++) drive5(1'b1, 1'b0, 8'(8'h21 + i), 1'b0, 1'b0);
    drive5(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
    total++; if (b5.count !== 3'd5) begin bad++; $display("FAIL full_push_count: got %0d want 5", b5.count); end
    total++; if (b5.overflow !== 1'b1) begin bad++; $display("FAIL full_push_ovf: got %b want 1", b5.overflow); end
    total++; if (b5.dout !== 8'h21) begin bad++; $display("FAIL full_push_head: got %h want 21", b5.dout); end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (b5.overflow !== exp_ovf5) begin bad++; $display("FAIL full_idle_ovf: got %b want %b", b5.overflow, exp_ovf5); end
    drive5(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    total++; if (rd_got5 !== 8'h21) begin bad++; $display("FAIL full_pp_old_head: got %h want 21", rd_got5); end
    total++; if (b5.count !== 3'd5) begin bad++; $display("FAIL full_pp_count: got %0d want 5", b5.count); end
    total++; if (b5.dout !== 8'h22) begin bad++; $display("FAIL full_pp_next_head: got %h want 22", b5.dout); end
    total++; if (b5.overflow !== exp_ovf5) begin bad++; $display("FAIL full_pp_ovf: got %b want %b", b5.overflow, exp_ovf5); end
    for (int i = 0; i < 5; i++) begin
      drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      total++; if (rd_got5 !== rd_exp5) begin bad++; $display("FAIL full_drain_data: got %h want %h", rd_got5, rd_exp5); end
    end
    total++; if (rd_got5 !== 8'h99) begin bad++; $display("FAIL full_last_is_99: got %h want 99", rd_got5); end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_empty_boundary();
    drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (b5.underflow !== 1'b1) begin bad++; $display("FAIL empty_pop_udf: got %b want 1", b5.underflow); end
    total++; if (b5.count !== 3'd0) begin bad++; $display("FAIL empty_pop_count: got %0d want 0", b5.count); end
    drive5(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
    total++; if (b5.count !== 3'd1) begin bad++; $display("FAIL empty_pp_count: got %0d want 1", b5.count); end
    total++; if (b5.dout !== 8'hA5) begin bad++; $display("FAIL empty_pp_dout: got %h want a5", b5.dout); end
    total++; if (b5.underflow !== 1'b1) begin bad++; $display("FAIL empty_pp_udf: got %b want 1", b5.underflow); end
    total++; if (b5.overflow !== 1'b0) begin bad++; $display("FAIL empty_pp_ovf: got %b want 0", b5.overflow); end
    drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (rd_got5 !== 8'hA5) begin bad++; $display("FAIL empty_read_a5: got %h want a5", rd_got5); end
    total++; if (b5.empty !== 1'b1) begin bad++; $display("FAIL empty_after_read: got %b want 1", b5.empty); end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic test_almost();
    logic [7:0] q[$];
    logic [7:0] got;
    logic [7:0] want;
    int c;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        b8.push = 1'b1; b8.din = 8'(8'h80 + i); q.push_back(8'(8'h80 + i));
        @(posedge clk); #1;
        b8.push = 1'b0;
      end
      c = i;
      total++; if (b8.count !== 4'(c)) begin bad++; $display("FAIL af_fill_count: got %0d want %0d", b8.count, c); end
      total++; if (b8.a_full !== (c >= 6)) begin bad++; $display("FAIL af_fill_a_full: count %0d got %b", c, b8.a_full); end
      total++; if (b8.a_empty !== (c <= 1)) begin bad++; $display("FAIL af_fill_a_empty: count %0d got %b", c, b8.a_empty); end
      total++; if (b8.full !== (c == 8)) begin bad++; $display("FAIL af_fill_full: count %0d got %b", c, b8.full); end
    end
    for (int i = 7; i >= 0; i--) begin
      b8.pop = 1'b1; got = b8.dout; want = q.pop_front();
      @(posedge clk); #1;
      b8.pop = 1'b0;
      c = i;
      total++; if (got !== want) begin bad++; $display("FAIL af_drain_data: got %h want %h", got, want); end
      total++; if (b8.a_full !== (c >= 6)) begin bad++; $display("FAIL af_drain_a_full: count %0d got %b", c, b8.a_full); end
      total++; if (b8.a_empty !== (c <= 1)) begin bad++; $display("FAIL af_drain_a_empty: count %0d got %b", c, b8.a_empty); end
      total++; if (b8.empty !== (c == 0)) begin bad++; $display("FAIL af_drain_empty: count %0d got %b", c, b8.empty); end
    end
  endtask

  task automatic test_flush_reset();
    for (int i = 0; i < 3; i++) drive5(1'b1, 1'b0, 8'(8'h31 + i), 1'b0, 1'b0);
    total++; if (b5.count !== 3'd3) begin bad++; $display("FAIL fl_pre_count: got %0d want 3", b5.count); end
    drive5(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
    total++; if (b5.count !== 3'd0) begin bad++; $display("FAIL fl_count: got %0d want 0", b5.count); end
    total++; if (b5.empty !== 1'b1) begin bad++; $display("FAIL fl_empty: got %b want 1", b5.empty); end
    total++; if (b5.dout !== 8'h00) begin bad++; $display("FAIL fl_dout: got %h want 00", b5.dout); end
    drive5(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    total++; if (b5.dout !== 8'h42) begin bad++; $display("FAIL fl_next_push: got %h want 42", b5.dout); end
    for (int i = 0; i < 3; i++) drive5(1'b1, 1'b0, 8'(8'h61 + i), 1'b0, 1'b0);
    total++; if (b5.count !== 3'd4) begin bad++; $display("FAIL rst_mid_pre: got %0d want 4", b5.count); end
    reset_cycles(1);
    total++; if (b5.count !== 3'd0) begin bad++; $display("FAIL rst_mid_count: got %0d want 0", b5.count); end
    total++; if (b5.empty !== 1'b1) begin bad++; $display("FAIL rst_mid_empty: got %b want 1", b5.empty); end
    total++; if (b5.dout !== 8'h00) begin bad++; $display("FAIL rst_mid_dout: got %h want 00", b5.dout); end
    drive5(1'b1, 1'b0, 8'h55, 1'b0, 1'b0);
    total++; if (b5.dout !== 8'h55) begin bad++; $display("FAIL rst_mid_push: got %h want 55", b5.dout); end
    drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (rd_got5 !== 8'h55) begin bad++; $display("FAIL rst_mid_pop: got %h want 55", rd_got5); end
  endtask

  task automatic test_errors();
    for (int i = 0; i < 5; i++) drive5(1'b1, 1'b0, 8'(8'hC1 + i), 1'b0, 1'b0);
    drive5(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
    total++; if (b5.overflow !== 1'b1) begin bad++; $display("FAIL err_ovf_set: got %b want 1", b5.overflow); end
    for (int i = 0; i < 10; i++) begin
      drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      total++; if (b5.overflow !== exp_ovf5) begin bad++; $display("FAIL err_ovf_hold: cycle %0d got %b want %b", i, b5.overflow, exp_ovf5); end
    end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (b5.overflow !== 1'b0) begin bad++; $display("FAIL err_ovf_clr: got %b want 0", b5.overflow); end
    drive5(1'b1, 1'b0, 8'hEF, 1'b0, 1'b1);
    total++; if (b5.overflow !== 1'b1) begin bad++; $display("FAIL err_clr_vs_set: got %b want 1", b5.overflow); end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    total++; if (b5.overflow !== exp_ovf5) begin bad++; $display("FAIL err_ovf_after: got %b want %b", b5.overflow, exp_ovf5); end
    for (int i = 0; i < 5; i++) drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    drive5(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    total++; if (b5.underflow !== 1'b1) begin bad++; $display("FAIL err_udf_set: got %b want 1", b5.underflow); end
    for (int i = 0; i < 3; i++) begin
      drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
      total++; if (b5.underflow !== exp_udf5) begin bad++; $display("FAIL err_udf_hold: cycle %0d got %b want %b", i, b5.underflow, exp_udf5); end
    end
    drive5(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    total++; if (b5.underflow !== 1'b0) begin bad++; $display("FAIL err_udf_clr: got %b want 0", b5.underflow); end
  endtask

  task automatic test_back_to_back();
    logic pu;
    logic po;
    for (int i = 0; i < 80; i++) begin
      pu = ($urandom_range(0, 99) < 55);
      po = ($urandom_range(0, 99) < 50);
      drive5(pu, po, 8'($urandom), 1'b0, 1'b0);
      total++; if (b5.count !== 3'(m_cnt5)) begin bad++; $display("FAIL b2b_count: got %0d want %0d", b5.count, m_cnt5); end
      total++; if (b5.dout !== head5()) begin bad++; $display("FAIL b2b_head: got %h want %h", b5.dout, head5()); end
      if (did_rd5) begin
        total++; if (rd_got5 !== rd_exp5) begin bad++; $display("FAIL b2b_data: got %h want %h", rd_got5, rd_exp5); end
      end
      total++; if (b5.overflow !== exp_ovf5 || b5.underflow !== exp_udf5) begin bad++; $display("FAIL b2b_err: got %b%b want %b%b", b5.overflow, b5.underflow, exp_ovf5, exp_udf5); end
    end
  endtask

  initial begin
    rst = 1'b1;
    b5.push = 1'b0; b5.pop = 1'b0; b5.flush = 1'b0; b5.err_clr = 1'b0; b5.din = 8'h00;
    b8.push = 1'b0; b8.pop = 1'b0; b8.flush = 1'b0; b8.err_clr = 1'b0; b8.din = 8'h00;
    m_cnt5 = 0; exp_ovf5 = 1'b0; exp_udf5 = 1'b0;
    did_rd5 = 1'b0; rd_exp5 = 8'h00; rd_got5 = 8'h00;
    test_reset();
    test_wrap();
    test_full_boundary();
    test_empty_boundary();
    test_almost();
    test_flush_reset();
    test_errors();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
